// File: rtl/instr_fetch_if.sv
// Fetch-side bus between instr_fetch_unit (master) and the core/instruction memory (slave).
interface instr_fetch_if;
    logic [31:0] pc_next;
    logic        redirect;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fault;

    modport master (
        input  pc_next, redirect, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, fault
    );

    modport slave (
        output pc_next, redirect, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch: owns the PC, issues one imem request at a time, holds instr under stall.
// Define FETCH_DELAY_SLOT_EN for branch-delay-slot redirect semantics.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q, imem_req_d;
    logic        fault_q, fault_d;
`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] target_q, target_d;
`endif

    logic [31:0] new_pc;
    logic        take_fault;
    logic        misaligned;

    assign misaligned = (bus.pc_next[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        fault_d       = fault_q;
`ifdef FETCH_DELAY_SLOT_EN
        pend_d        = pend_q;
        target_d      = target_q;
`endif
        new_pc        = pc_plus4_q;
        take_fault    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                imem_req_d = 1'b1;
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    instr_d       = bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.stall) begin
`ifdef FETCH_DELAY_SLOT_EN
                    // Delay slot: the instruction after a taken branch is fetched before the target.
                    if (pend_q) begin
                        new_pc = target_q;
                        pend_d = 1'b0;
                    end else if (bus.redirect) begin
                        if (misaligned) begin
                            take_fault = 1'b1;
                        end else begin
                            target_d = bus.pc_next;
                            pend_d   = 1'b1;
                        end
                    end
`else
                    if (bus.redirect) begin
                        if (misaligned) take_fault = 1'b1;
                        else            new_pc     = bus.pc_next;
                    end
`endif
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    if (take_fault) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pc_d       = new_pc;
                        pc_plus4_d = new_pc + 32'd4;
                        imem_req_d = 1'b1;
                        state_d    = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + 32'd4;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            fault_q       <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q        <= 1'b0;
            target_q      <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            fault_q       <= fault_d;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q        <= pend_d;
            target_q      <= target_d;
`endif
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level PC model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural fetch address and last delivered word
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_pend;
    logic [31:0] m_target;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_instr  = NOP_INSTR;
        m_pend   = 1'b0;
        m_target = 32'd0;
    endtask

    task automatic idle_inputs();
        bus.stall      = 1'b1;
        bus.redirect   = 1'b0;
        bus.pc_next    = 32'd0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    // Wait for a request, hold ack off for lat cycles, then return data.
    task automatic serve(input int lat, input logic [31:0] data);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL serve_timeout: imem_req=%b required 1", bus.imem_req);
            return;
        end
        checks++;
        if (bus.imem_addr !== m_pc) begin
            errors++;
            $display("FAIL imem_addr: got %h required %h", bus.imem_addr, m_pc);
        end
        for (int i = 0; i < lat; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_hold: req=%b addr=%h valid=%b required 1/%h/0",
                         bus.imem_req, bus.imem_addr, bus.instr_valid, m_pc);
            end
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        m_instr = data;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: valid=%b instr=%h req=%b required 1/%h/0",
                     bus.instr_valid, bus.instr, bus.imem_req, data);
        end
        checks++;
        if (bus.pc !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin
            errors++;
            $display("FAIL fetch_pc: pc=%h pc_plus4=%h required %h/%h",
                     bus.pc, bus.pc_plus4, m_pc, m_pc + 32'd4);
        end
    endtask

    // Stall cycles: outputs frozen while redirect/pc_next/ack wiggle.
    task automatic stall_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.stall      = 1'b1;
            bus.redirect   = $urandom_range(0, 1);
            bus.pc_next    = $urandom;
            bus.imem_ack   = $urandom_range(0, 1);
            bus.imem_rdata = $urandom;
            tick();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== m_instr || bus.pc !== m_pc ||
                bus.imem_req !== 1'b0 || bus.fault !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b instr=%h pc=%h req=%b fault=%b required 1/%h/%h/0/0",
                         bus.instr_valid, bus.instr, bus.pc, bus.imem_req, bus.fault, m_instr, m_pc);
            end
        end
        idle_inputs();
    endtask

    // Consume the held instruction; expected next PC comes from the branch rules.
    task automatic consume(input logic rd, input logic [31:0] tgt);
        logic        exp_fault;
        logic [31:0] nxt;
        exp_fault = 1'b0;
        nxt       = m_pc + 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
        if (m_pend) begin
            nxt    = m_target;
            m_pend = 1'b0;
        end else if (rd) begin
            if (tgt[1:0] != 2'b00) exp_fault = 1'b1;
            else begin
                m_target = tgt;
                m_pend   = 1'b1;
            end
        end
`else
        if (rd) begin
            if (tgt[1:0] != 2'b00) exp_fault = 1'b1;
            else nxt = tgt;
        end
`endif
        bus.stall    = 1'b0;
        bus.redirect = rd;
        bus.pc_next  = tgt;
        tick();
        idle_inputs();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== NOP_INSTR) begin
            errors++;
            $display("FAIL consume_clear: valid=%b instr=%h required 0/%h",
                     bus.instr_valid, bus.instr, NOP_INSTR);
        end
        if (exp_fault) begin
            checks++;
            if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc !== m_pc) begin
                errors++;
                $display("FAIL fault_entry: fault=%b req=%b pc=%h required 1/0/%h",
                         bus.fault, bus.imem_req, bus.pc, m_pc);
            end
        end else begin
            m_pc = nxt;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== nxt ||
                bus.pc_plus4 !== nxt + 32'd4 || bus.fault !== 1'b0) begin
                errors++;
                $display("FAIL next_req: req=%b addr=%h pc_plus4=%h fault=%b required 1/%h/%h/0",
                         bus.imem_req, bus.imem_addr, bus.pc_plus4, bus.fault, nxt, nxt + 32'd4);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.imem_ack = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.imem_req !== 1'b0 || bus.pc !== RESET_PC || bus.pc_plus4 !== RESET_PC + 32'd4 ||
            bus.instr !== NOP_INSTR || bus.instr_valid !== 1'b0 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b pc=%h pc4=%h instr=%h valid=%b fault=%b required 0/%h/%h/%h/0/0",
                     bus.imem_req, bus.pc, bus.pc_plus4, bus.instr, bus.instr_valid, bus.fault,
                     RESET_PC, RESET_PC + 32'd4, NOP_INSTR);
        end
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: imem_req=%b required 0", bus.imem_req);
        end
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_first_fetch();
        serve(0, 32'h0c10_0008);
        checks++;
        if (bus.instr !== 32'h0c10_0008 || bus.pc_plus4 !== 32'h0040_0004) begin
            errors++;
            $display("FAIL first_fetch: instr=%h pc_plus4=%h required 0c100008/00400004",
                     bus.instr, bus.pc_plus4);
        end
    endtask

    task automatic test_sequential();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_pc !== RESET_PC + 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_model: pc=%h required %h", m_pc, RESET_PC + 32'(4 * i));
            end
            serve(2, $urandom);
            consume(1'b0, 32'd0);
        end
        serve(1, $urandom);
    endtask

    task automatic test_stall();
        stall_cycles(5);
        consume(1'b0, 32'd0);
        serve(0, $urandom);
    endtask

    task automatic test_redirect();
        reset_dut();
        serve(0, $urandom);
        consume(1'b1, 32'h0040_006c);
        if (m_pc != 32'h0040_006c) begin
            serve(0, $urandom);
            consume(1'b0, 32'd0);
        end
        serve(1, $urandom);
        checks++;
        if (bus.pc !== 32'h0040_006c) begin
            errors++;
            $display("FAIL redirect_setup: pc=%h required 0040006c", bus.pc);
        end
        consume(1'b1, 32'h0040_0020);
        checks++;
`ifdef FETCH_DELAY_SLOT_EN
        if (bus.imem_addr !== 32'h0040_0070) begin
            errors++;
            $display("FAIL delay_slot_addr: addr=%h required 00400070", bus.imem_addr);
        end
        serve(0, $urandom);
        consume(1'b1, 32'h0040_0400);
        checks++;
`endif
        if (bus.imem_addr !== 32'h0040_0020) begin
            errors++;
            $display("FAIL redirect_addr: addr=%h required 00400020", bus.imem_addr);
        end
        serve(0, $urandom);
        // Sequential wrap from the top of the address space.
        consume(1'b1, 32'hFFFF_FFFC);
        if (m_pc != 32'hFFFF_FFFC) begin
            serve(0, $urandom);
            consume(1'b0, 32'd0);
        end
        serve(0, $urandom);
        consume(1'b0, 32'd0);
        serve(0, $urandom);
        checks++;
        if (bus.pc !== 32'd0 || bus.pc_plus4 !== 32'd4 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL wrap: pc=%h pc_plus4=%h fault=%b required 0/4/0", bus.pc, bus.pc_plus4, bus.fault);
        end
    endtask

    task automatic test_fault();
        reset_dut();
        serve(0, $urandom);
        consume(1'b1, 32'h0040_0022);
        for (int i = 0; i < 5; i++) begin
            bus.stall      = $urandom_range(0, 1);
            bus.redirect   = $urandom_range(0, 1);
            bus.pc_next    = $urandom;
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = $urandom;
            tick();
            checks++;
            if (bus.fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fault_sticky: fault=%b req=%b valid=%b required 1/0/0",
                         bus.fault, bus.imem_req, bus.instr_valid);
            end
        end
        reset_dut();
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: fault=%b required 0", bus.fault);
        end
        serve(0, $urandom);
    endtask

    task automatic test_reset_mid_req();
        reset_dut();
        tick();
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_setup: req=%b required 1", bus.imem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b required 0", bus.imem_req);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== NOP_INSTR || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL late_ack: valid=%b instr=%h addr=%h required 0/%h/%h",
                     bus.instr_valid, bus.instr, bus.imem_addr, NOP_INSTR, RESET_PC);
        end
        serve(1, 32'h2402_0001);
    endtask

    task automatic test_random();
        logic        rd;
        logic [31:0] tgt;
        reset_dut();
        for (int t = 0; t < 60; t++) begin
            serve($urandom_range(0, 3), $urandom);
            stall_cycles($urandom_range(0, 3));
            rd  = ($urandom_range(0, 3) == 0);
            tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            consume(rd, tgt[31:0]);
        end
        serve(0, $urandom);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_first_fetch();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
